// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and its bench:
// FSM state encodings and the opcode/function codes the ALU understands.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/Alu_Top.sv
// Combinational ALU: R-type add/and/slt, lw address add, beq subtract.
// zero flags an all-zero result; unknown codes produce 0.
module Alu_Top
    import alu_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [5:0]    opcode,
    input  logic [5:0]    func_field,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    output logic [DW-1:0] result,
    output logic          zero
);

    // Decode opcode/function and compute the result plus zero flag.
    always_comb begin
        result = '0;
        case (opcode)
            OP_RTYPE: begin
                case (func_field)
                    FN_ADD:  result = A + B;
                    FN_AND:  result = A & B;
                    FN_SLT:  result = {{(DW-1){1'b0}}, ($signed(A) < $signed(B))};
                    default: result = '0;
                endcase
            end
            OP_LW:   result = A + B;
            OP_BEQ:  result = A - B;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. With both requests present the side that did
// not win last time is chosen; a lone request always wins. en gates the
// one-hot grant but gnt_idx is always the would-be winner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // Pick the winner and form the gated one-hot grant.
    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
        gnt = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with
// round-robin arbitration. One operation in flight at a time.
// Optional macro ALU_ARB_STATS_EN enables saturating per-requester grant
// counters; without it grant_cnt0/1 read as zero.
//
// state   | meaning
// IDLE    | waiting for a request; winner sees req_ready and is registered
// EXEC    | ALU driven from registered operands; result captured at cycle end
// RESP    | rsp_valid to the granted requester until its rsp_ready
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req0_opcode,
    input  logic [5:0]       req0_func,
    input  logic [DW-1:0]    req0_a,
    input  logic [DW-1:0]    req0_b,
    input  logic [5:0]       req1_opcode,
    input  logic [5:0]       req1_func,
    input  logic [DW-1:0]    req1_a,
    input  logic [DW-1:0]    req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [DW-1:0]    rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          gnt_q;
    logic          last_q;
    logic [5:0]    opcode_q;
    logic [5:0]    func_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic [1:0]    arb_gnt;
    logic          arb_idx;
    logic          arb_en;
    logic          accept;

    // Ready must stay low while reset is asserted even though state reads IDLE.
    assign arb_en    = (state_q == ST_IDLE) && !rst;
    assign req_ready = arb_gnt;
    assign accept    = |arb_gnt;
    assign busy      = (state_q != ST_IDLE);

    rr_arb2 u_arb (
        .req     (req_valid),
        .last    (last_q),
        .en      (arb_en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    Alu_Top #(.DW(DW)) u_alu (
        .opcode     (opcode_q),
        .func_field (func_q),
        .A          (a_q),
        .B          (b_q),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and response-valid decode.
    always_comb begin
        state_d   = state_q;
        rsp_valid = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = gnt_q ? 2'b10 : 2'b01;
                if (rsp_ready[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the winner's payload on accept and the ALU output at end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            opcode_q   <= '0;
            func_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                gnt_q    <= arb_idx;
                last_q   <= arb_idx;
                opcode_q <= arb_idx ? req1_opcode : req0_opcode;
                func_q   <= arb_idx ? req1_func   : req0_func;
                a_q      <= arb_idx ? req1_a      : req0_a;
                b_q      <= arb_idx ? req1_b      : req0_b;
            end
            if (state_q == ST_EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating grant counters, one per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (!arb_idx && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (arb_idx && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
